// File: rtl/pll_nco_multi.sv
// rtl/pll_nco_multi.sv - multi-channel NCO clock-enable generator with lock qualifier
//
// Ports:
//   refclk     sole clock, rising edge
//   rst        synchronous active-high reset
//   ref_ok     upstream hard PLL locked, qualifies lock counting
//   inc        per-channel increment, channel k at [k*ACC_W +: ACC_W]
//   inc_load   strobe, captures inc into the active increment registers
//   phase_rst  per-channel accumulator clear
//   outclk_en  one-cycle enable pulse per output period
//   outclk     ~50% square wave (registered accumulator MSB)
//   locked     outputs valid and stable
module pll_nco_multi #(
  parameter int NUM_CH        = 2,
  parameter int ACC_W         = 32,
  parameter int LOCK_CYCLES   = 1024,
  parameter int GATE_UNLOCKED = 1
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    ref_ok,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic                    inc_load,
  input  logic [NUM_CH-1:0]       phase_rst,
  output logic [NUM_CH-1:0]       outclk_en,
  output logic [NUM_CH-1:0]       outclk,
  output logic                    locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic GATE = (GATE_UNLOCKED != 0);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_COUNTING = 2'd1,
    S_LOCKED   = 2'd2
  } lock_state_t;

  lock_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] en_q;
  logic              gate_open;

  // Gating uses the registered lock flag, so outclk_en can never be high
  // in a cycle where locked reads 0.
  assign gate_open = locked | ~GATE;
  assign outclk_en = en_q & {NUM_CH{gate_open}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W:0]   sum;
    logic             en_r;
    logic             clk_r;

    // Carry out of the ACC_W+1-bit add marks one output period.
    assign sum     = {1'b0, acc} + {1'b0, inc_act};
    assign en_q[k] = en_r;
    assign outclk[k] = clk_r;

    always_ff @(posedge refclk) begin
      if (rst) begin
        acc     <= '0;
        inc_act <= '0;
        en_r    <= 1'b0;
        clk_r   <= 1'b0;
      end else begin
        // New increment takes effect on the following accumulation.
        if (inc_load) inc_act <= inc[k*ACC_W +: ACC_W];
        clk_r <= acc[ACC_W-1];
        if (phase_rst[k]) begin
          acc  <= '0;
          en_r <= 1'b0;
        end else begin
          acc  <= sum[ACC_W-1:0];
          en_r <= sum[ACC_W];
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state  <= S_UNLOCKED;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        S_UNLOCKED: begin
          cnt    <= '0;
          locked <= 1'b0;
          if (ref_ok && !inc_load) begin
            state <= S_COUNTING;
            cnt   <= CNT_ONE;
          end
        end
        S_COUNTING: begin
          locked <= 1'b0;
          if (!ref_ok) begin
            state <= S_UNLOCKED;
            cnt   <= '0;
          end else if (inc_load) begin
            cnt <= '0;
          end else if (cnt >= CNT_TOP) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_LOCKED: begin
          if (!ref_ok) begin
            state  <= S_UNLOCKED;
            cnt    <= '0;
            locked <= 1'b0;
          end else if (inc_load) begin
            state  <= S_COUNTING;
            cnt    <= '0;
            locked <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
        end
        default: begin
          state  <= S_UNLOCKED;
          cnt    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_nco_multi.sv
// tb/tb_pll_nco_multi.sv - scoreboard bench for pll_nco_multi
module tb_pll_nco_multi;

  logic        refclk;
  logic        rst;
  logic        ref_ok;
  logic [15:0] inc;
  logic        inc_load;
  logic [1:0]  phase_rst;
  logic [1:0]  outclk_en;
  logic [1:0]  outclk;
  logic        locked;

  logic        f_rst;
  logic        f_ref_ok;
  logic [31:0] f_inc;
  logic        f_load;
  logic [0:0]  f_prst;
  logic [0:0]  f_en;
  logic [0:0]  f_clk;
  logic        f_locked;

  pll_nco_multi #(.NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(16), .GATE_UNLOCKED(1)) u_dut (
    .refclk(refclk), .rst(rst), .ref_ok(ref_ok), .inc(inc), .inc_load(inc_load),
    .phase_rst(phase_rst), .outclk_en(outclk_en), .outclk(outclk), .locked(locked)
  );

  pll_nco_multi #(.NUM_CH(1), .ACC_W(32), .LOCK_CYCLES(4), .GATE_UNLOCKED(1)) u_frac (
    .refclk(refclk), .rst(f_rst), .ref_ok(f_ref_ok), .inc(f_inc), .inc_load(f_load),
    .phase_rst(f_prst), .outclk_en(f_en), .outclk(f_clk), .locked(f_locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  // sel: 0 locked, 1 outclk_en, 2 outclk[0], 3 outclk[1]
  typedef struct {
    int         cyc;
    int         sel;
    logic [1:0] val;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  task automatic push(input int c, input int sel, input logic [1:0] v);
    sbq.push_back('{c, sel, v});
  endtask

  always @(negedge refclk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) check("stale_expect", e.cyc, 32'(cyc), 32'(e.cyc));
      else begin
        case (e.sel)
          0:       check("locked", cyc, {31'b0, locked}, {30'b0, e.val});
          1:       check("outclk_en", cyc, {30'b0, outclk_en}, {30'b0, e.val});
          2:       check("outclk0", cyc, {31'b0, outclk[0]}, {30'b0, e.val});
          default: check("outclk1", cyc, {31'b0, outclk[1]}, {30'b0, e.val});
        endcase
      end
    end
  end

  // Reference state: per-channel origin cycle (acc==0), increment, lock cycle.
  int org[2];
  int incv[2];
  int lock_at;

  task automatic push_model(input int c);
    logic       lk;
    logic [1:0] en;
    int         j;
    lk = (c >= lock_at);
    push(c, 0, {1'b0, lk});
    for (int ch = 0; ch < 2; ch++) begin
      j = c - org[ch];
      en[ch] = lk && (j >= 1) && ((incv[ch] * j) / 256 != (incv[ch] * (j - 1)) / 256);
      if (j >= 1) push(c, 2 + ch, {1'b0, ((incv[ch] * (j - 1)) % 256) >= 128});
    end
    push(c, 1, en);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      push_model(cyc + 1);
      @(negedge refclk);
    end
  endtask

  task automatic ev_reset();
    org[0] = cyc + 1;
    org[1] = cyc + 1;
    incv[0] = 0;
    incv[1] = 0;
    lock_at = cyc + 17;
    push(cyc + 1, 2, 2'b00);
    push(cyc + 1, 3, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  longint exp_pulses;
  int     fcnt;
  int     last;
  int     bad;

  initial begin
    rst = 1'b1; ref_ok = 1'b0; inc = '0; inc_load = 1'b0; phase_rst = '0;
    f_rst = 1'b1; f_ref_ok = 1'b0; f_inc = '0; f_load = 1'b0; f_prst = '0;
    org[0] = 0; org[1] = 0; incv[0] = 0; incv[1] = 0; lock_at = 0;
    @(negedge refclk);

    // Reset, then lock 16 cycles later with ref_ok held
    rst = 1'b1; ref_ok = 1'b1;
    ev_reset();
    run(1);
    rst = 1'b0;
    run(16);

    // Reprogram while locked: ch0=128, ch1=64; relock and pulse trains
    inc = {8'd64, 8'd128}; inc_load = 1'b1;
    incv[0] = 128; incv[1] = 64;
    org[0] = cyc + 1; org[1] = cyc + 1;
    lock_at = cyc + 17;
    run(1);
    inc_load = 1'b0;
    run(24);

    // Load with phase reset on both channels: ch0=32, ch1=128
    inc = {8'd128, 8'd32}; inc_load = 1'b1; phase_rst = 2'b11;
    incv[0] = 32; incv[1] = 128;
    org[0] = cyc + 1; org[1] = cyc + 1;
    lock_at = cyc + 17;
    run(1);
    inc_load = 1'b0; phase_rst = 2'b00;
    run(20);

    // Phase reset of channel 0 only, mid-period
    phase_rst = 2'b01;
    org[0] = cyc + 1;
    run(1);
    phase_rst = 2'b00;
    run(12);

    // One-cycle ref_ok loss while locked
    ref_ok = 1'b0;
    lock_at = cyc + 17;
    run(1);
    ref_ok = 1'b1;
    run(20);

    // Reset mid-run: outputs clear, no pulses afterwards without a reload
    rst = 1'b1;
    ev_reset();
    run(1);
    rst = 1'b0;
    run(24);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge refclk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain cyc=%0d got=%0d exp=0 pending", cyc, sbq.size());
    end

    // Fractional rate on a 32-bit channel
    f_rst = 1'b1;
    @(negedge refclk);
    f_rst = 1'b0; f_ref_ok = 1'b1; f_load = 1'b1; f_inc = 32'd2108416626;
    @(negedge refclk);
    f_load = 1'b0;
    for (int i = 0; i < 40 && !f_locked; i++) @(negedge refclk);
    check("frac_locked", cyc, {31'b0, f_locked}, 32'd1);
    fcnt = 0; last = -1; bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge refclk);
      if (f_en[0]) begin
        if (last >= 0 && ((i - last) < 2 || (i - last) > 3)) bad++;
        last = i;
        fcnt++;
      end
    end
    exp_pulses = (64'd10000 * 64'd2108416626) >> 32;
    n_checks++;
    if (longint'(fcnt) < exp_pulses - 1 || longint'(fcnt) > exp_pulses + 1) begin
      n_fail++;
      $display("FAIL frac_count got=%0d exp=%0d+-1", fcnt, exp_pulses);
    end
    check("frac_gaps", cyc, 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
